sram_ctrl: RTL and testbench

Multi-cycle controller that sequences the 16-bit external data SRAM on behalf of the MEM stage of the 5-stage ARM pipeline. It takes the 32-bit load/store request (ALU result as address, val_rm as store data) and performs it as two 16-bit SRAM accesses with programmable wait states. While an access is in flight it deasserts `ready`, and the top level uses that signal to freeze every pipeline register. An optional one-entry posted-write buffer lets stores retire without stalling.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_phase_cnt.sv | 31 +++
 rtl/sram_ctrl.sv | 122 ++++++++++++
 tb/tb_sram_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam int unsigned ADDR_BASE_DEFAULT = 1024;
    localparam int unsigned CNT_W             = 4;

    typedef logic [15:0] half_t;

endpackage

// File: rtl/sram_phase_cnt.sv
// Wait-state counter for one SRAM phase: counts 0..MAX and flags the last cycle.
module sram_phase_cnt
    import sram_pkg::*;
#(
    parameter int unsigned MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic last,
    output logic last_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(MAX - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (!last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_MAX);
    // Lets the registered SRAM strobes anticipate the last (address-hold) cycle.
    assign last_next = !clr && (cnt == CNT_PEN);

endmodule

// File: rtl/sram_ctrl.sv
// Two-phase 16-bit SRAM sequencer for 32-bit MEM-stage loads/stores.
// Optional posted-write buffer enabled by defining SRAM_CTRL_WBUF_EN.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output half_t              sram_dq_out,
    output logic               sram_dq_oe,
    input  half_t              sram_dq_in,
    output logic               sram_we_n
);

    localparam logic [31:0] BASE = 32'(ADDR_BASE);

    state_t state, next_state;
    logic   req, clr, last, last_next, skip_done;
    logic   src_store;
    logic [31:0] src_addr, src_data, byte_off;
    logic [SRAM_AW-2:0] word_idx;
    logic   unused_off;

    assign req = rd_en | wr_en;

`ifdef SRAM_CTRL_WBUF_EN
    logic        buf_valid, post;
    logic [31:0] buf_addr, buf_data;

    assign post = (state == IDLE) && !buf_valid && wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (post) begin
            buf_valid <= 1'b1;
            buf_addr  <= address;
            buf_data  <= wr_data;
        end else if (state == HI && last) begin
            buf_valid <= 1'b0;
        end
    end

    // The buffer is only written while empty, so on the posting edge the inputs are the source.
    assign src_store = buf_valid | wr_en;
    assign src_addr  = buf_valid ? buf_addr : address;
    assign src_data  = buf_valid ? buf_data : wr_data;
    assign skip_done = buf_valid;
    assign ready     = !req || (state == DONE) || post;
`else
    assign src_store = wr_en;
    assign src_addr  = address;
    assign src_data  = wr_data;
    assign skip_done = 1'b0;
    assign ready     = !req || (state == DONE);
`endif

    assign byte_off   = src_addr - BASE;
    assign word_idx   = byte_off[SRAM_AW:2];
    assign unused_off = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = LO;
            LO:   if (last) next_state = HI;
            HI:   if (last) next_state = skip_done ? IDLE : DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign clr = !(((state == LO) || (state == HI)) && (next_state == state));

    sram_phase_cnt #(
        .MAX (WAIT_CYCLES)
    ) u_phase_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .last      (last),
        .last_next (last_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            if (state == LO && last && !src_store) rd_data[15:0]  <= sram_dq_in;
            if (state == HI && last && !src_store) rd_data[31:16] <= sram_dq_in;
            if (next_state == LO || next_state == HI) begin
                sram_addr   <= {word_idx, next_state == HI};
                sram_dq_out <= (next_state == HI) ? src_data[31:16] : src_data[15:0];
                sram_dq_oe  <= src_store;
                sram_we_n   <= !(src_store && !last_next);
            end else begin
                sram_dq_oe  <= 1'b0;
                sram_we_n   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed-vector bench for sram_ctrl with a small behavioural SRAM.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:63];
    logic        unused_hi;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    assign sram_dq_in = mem[sram_addr[5:0]];
    assign unused_hi  = ^sram_addr[17:6];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        rst = 1'b0;
        #2;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready); end
        vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
        vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", sram_dq_oe); end
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data got %h want 00000000", rd_data); end
    endtask

    task automatic test_store();
        logic [7:0] rdy_exp = 8'b1000_0000;
        logic [7:0] we_exp  = 8'b1100_1001;
        cyc();
        wr_en = 1'b1; address = 32'd1024; wr_data = 32'hDEADBEEF;
        #2;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin cyc(); #2; end
            vectors++; if (ready !== rdy_exp[c]) begin miscompares++; $display("FAIL store_ready c%0d got %b want %b", c, ready, rdy_exp[c]); end
            vectors++; if (sram_we_n !== we_exp[c]) begin miscompares++; $display("FAIL store_we_n c%0d got %b want %b", c, sram_we_n, we_exp[c]); end
        end
        vectors++; if (mem[0] !== 16'hBEEF) begin miscompares++; $display("FAIL store_word0 got %h want beef", mem[0]); end
        vectors++; if (mem[1] !== 16'hDEAD) begin miscompares++; $display("FAIL store_word1 got %h want dead", mem[1]); end
        wr_en = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] rdy_exp = 8'b1000_0000;
        cyc();
        rd_en = 1'b1; address = 32'd1024;
        #2;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin cyc(); #2; end
            vectors++; if (ready !== rdy_exp[c]) begin miscompares++; $display("FAIL load_ready c%0d got %b want %b", c, ready, rdy_exp[c]); end
            vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL load_oe c%0d got %b want 0", c, sram_dq_oe); end
        end
        vectors++; if (rd_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_rd_data got %h want deadbeef", rd_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_store_addr();
        cyc();
        wr_en = 1'b1; address = 32'd1036; wr_data = 32'h0BADCAFE;
        #2;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin cyc(); #2; end
            if (c == 1) begin
                vectors++; if (sram_addr !== 18'd6) begin miscompares++; $display("FAIL addr_lo got %0d want 6", sram_addr); end
                vectors++; if (sram_dq_out !== 16'hCAFE) begin miscompares++; $display("FAIL dq_lo got %h want cafe", sram_dq_out); end
                vectors++; if (sram_dq_oe !== 1'b1) begin miscompares++; $display("FAIL oe_lo got %b want 1", sram_dq_oe); end
            end
            if (c == 4) begin
                vectors++; if (sram_addr !== 18'd7) begin miscompares++; $display("FAIL addr_hi got %0d want 7", sram_addr); end
                vectors++; if (sram_dq_out !== 16'h0BAD) begin miscompares++; $display("FAIL dq_hi got %h want 0bad", sram_dq_out); end
            end
        end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL addr_done_ready got %b want 1", ready); end
        vectors++; if ({mem[7], mem[6]} !== 32'h0BADCAFE) begin miscompares++; $display("FAIL addr_mem got %h want 0badcafe", {mem[7], mem[6]}); end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] rdy_exp = 8'b1000_0000;
        cyc();
        wr_en = 1'b1; address = 32'd1040; wr_data = 32'h11112222;
        #2;
        for (int c = 1; c < 6; c++) begin cyc(); #2; end
        rst = 1'b1; wr_en = 1'b0;
        cyc(); #2;
        vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL rstmid_we_n got %b want 1", sram_we_n); end
        vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rstmid_oe got %b want 0", sram_dq_oe); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", ready); end
        vectors++; if (sram_addr !== 18'd0) begin miscompares++; $display("FAIL rstmid_addr got %0d want 0", sram_addr); end
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_rd_data got %h want 00000000", rd_data); end
        rst = 1'b0;
        cyc();
        rd_en = 1'b1; address = 32'd1024;
        #2;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin cyc(); #2; end
            vectors++; if (ready !== rdy_exp[c]) begin miscompares++; $display("FAIL rstmid_load_ready c%0d got %b want %b", c, ready, rdy_exp[c]); end
        end
        vectors++; if (rd_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rstmid_load_data got %h want deadbeef", rd_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_wbuf_posted();
        cyc();
        wr_en = 1'b1; address = 32'd1028; wr_data = 32'h12345678;
        #2;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL wbuf_post_ready got %b want 1", ready); end
        cyc();
        wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; wr_data = '0;
        #2;
        for (int c = 1; c < 15; c++) begin
            if (c > 1) begin cyc(); #2; end
            vectors++; if (ready !== (c == 14)) begin miscompares++; $display("FAIL wbuf_ready c%0d got %b want %b", c, ready, c == 14); end
        end
        vectors++; if (rd_data !== 32'hA001A000) begin miscompares++; $display("FAIL wbuf_rd_data got %h want a001a000", rd_data); end
        vectors++; if ({mem[3], mem[2]} !== 32'h12345678) begin miscompares++; $display("FAIL wbuf_mem got %h want 12345678", {mem[3], mem[2]}); end
        rd_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
        test_reset();
`ifdef SRAM_CTRL_WBUF_EN
        test_wbuf_posted();
`else
        test_store();
        test_load();
        test_store_addr();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
